// File: rtl/addr_gen_nd.sv
// addr_gen_nd
// N-level nested-loop address generator for L2 RAM read/write streams.
// A start pulse latches the configuration into shadow registers. The block
// then emits one address per accepted beat over a valid/ready handshake.
// Loop 0 is the innermost loop. Each loop i runs cnt = 0..lenth[i] and
// adds gap[i] to its partial address on every step. The emitted address is
// base + sum(loop_addr[i]), taken mod 2^ADDR_W.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_base_addr       stream base address
//   cfg_gap[i]          address stride of loop i
//   cfg_lenth[i]        last counter value of loop i (lenth+1 iterations)
//   cfg_repeat          1: wrap to first beat after last, 0: stop
//   start               one-cycle start pulse (ignored while running)
//   abort               synchronous stop, back to IDLE, no done pulse
//   addr_valid/ready    beat handshake
//   addr, addr_last     current address, final-beat-of-pass flag
//   busy                generator is running
//   done                one-cycle pulse after the final beat is accepted
module addr_gen_nd #(
    parameter int ADDR_W = 13,
    parameter int LOOPS  = 4,
    parameter int CNT_W  = 13
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_W-1:0]              cfg_base_addr,
    input  logic [LOOPS-1:0][ADDR_W-1:0]   cfg_gap,
    input  logic [LOOPS-1:0][CNT_W-1:0]    cfg_lenth,
    input  logic                           cfg_repeat,
    input  logic                           start,
    input  logic                           abort,
    output logic                           addr_valid,
    input  logic                           addr_ready,
    output logic [ADDR_W-1:0]              addr,
    output logic                           addr_last,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               base_q, base_d;
    logic [LOOPS-1:0][ADDR_W-1:0]    gap_q, gap_d;
    logic [LOOPS-1:0][CNT_W-1:0]     len_q, len_d;
    logic                            rep_q, rep_d;
    logic [LOOPS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [LOOPS-1:0][ADDR_W-1:0]    laddr_q, laddr_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic                            last_q, last_d;
    logic                            done_q, done_d;

    // Wrapping sum of base and all per-loop partial addresses.
    function automatic logic [ADDR_W-1:0] addr_sum(
        input logic [ADDR_W-1:0]            b,
        input logic [LOOPS-1:0][ADDR_W-1:0] la
    );
        logic [ADDR_W-1:0] s;
        s = b;
        for (int i = 0; i < LOOPS; i++) begin
            s = s + la[i];
        end
        return s;
    endfunction

    // True when every counter sits at its terminal value (final beat of a pass).
    function automatic logic all_at_len(
        input logic [LOOPS-1:0][CNT_W-1:0] c,
        input logic [LOOPS-1:0][CNT_W-1:0] l
    );
        logic r;
        r = 1'b1;
        for (int i = 0; i < LOOPS; i++) begin
            if (c[i] != l[i]) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

    always_comb begin
        logic carry;
        state_d = state_q;
        base_d  = base_q;
        gap_d   = gap_q;
        len_d   = len_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        laddr_d = laddr_q;
        addr_d  = addr_q;
        last_d  = last_q;
        done_d  = 1'b0;
        carry   = 1'b1;

        case (state_q)
            IDLE: begin
                // abort wins over start, so a simultaneous pair leaves us idle
                if (start && !abort) begin
                    base_d  = cfg_base_addr;
                    gap_d   = cfg_gap;
                    len_d   = cfg_lenth;
                    rep_d   = cfg_repeat;
                    cnt_d   = '0;
                    laddr_d = '0;
                    addr_d  = cfg_base_addr;
                    last_d  = all_at_len('0, cfg_lenth);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else if (addr_ready) begin
                    if (last_q) begin
                        done_d = 1'b1;
                        if (rep_q) begin
                            cnt_d   = '0;
                            laddr_d = '0;
                            addr_d  = base_q;
                            last_d  = all_at_len('0, len_q);
                        end else begin
                            state_d = IDLE;
                            last_d  = 1'b0;
                        end
                    end else begin
                        // Ripple-carry across loops: loop i steps only when
                        // all inner loops are at their terminal value.
                        for (int i = 0; i < LOOPS; i++) begin
                            if (carry) begin
                                if (cnt_q[i] == len_q[i]) begin
                                    cnt_d[i]   = '0;
                                    laddr_d[i] = '0;
                                end else begin
                                    cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                                    laddr_d[i] = laddr_q[i] + gap_q[i];
                                    carry      = 1'b0;
                                end
                            end
                        end
                        addr_d = addr_sum(base_q, laddr_d);
                        last_d = all_at_len(cnt_d, len_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            gap_q   <= '0;
            len_q   <= '0;
            rep_q   <= 1'b0;
            cnt_q   <= '0;
            laddr_q <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            gap_q   <= gap_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            laddr_q <= laddr_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // The state register drives valid/busy directly, so they stay registered.
    assign addr_valid = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign addr       = addr_q;
    assign addr_last  = last_q;
    assign done       = done_q;

endmodule
